wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
//  Two-master -> one-slave Wishbone arbiter for the shared on-chip memory (ROM/RAM block).
//  Master 0 = instruction fetch, master 1 = load/store unit. Grants are round-robin with
//  cycle lock. A watchdog returns err on a stalled slave. Slave side drives WISHBONE_IF.master.
// PARAMETERS
//  ADDR_W   32  address width, all ports
//  DATA_W   32  data width, all ports
//  TIMEOUT  16  cycles with stb high and no ack before err is raised (>=2)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  mN_cyc         in   1       master N (N=0,1) bus cycle valid
//  mN_stb         in   1       master N strobe
//  mN_we          in   1       master N write enable
//  mN_addr        in   ADDR_W  master N byte address
//  mN_width       in   2       master N size: 00 byte, 01 half, 1x word
//  mN_data_write  in   DATA_W  master N write data
//  mN_data_read   out  DATA_W  master N read data; 0 when not granted
//  mN_ack         out  1       master N ack; slave ack passed through when granted
//  mN_err         out  1       master N timeout error, 1-cycle pulse
//  s_cyc/s_stb/s_we out 1      slave controls from granted master; 0 when IDLE
//  s_addr         out  ADDR_W  slave address; 0 when IDLE
//  s_width        out  2       slave size; 0 when IDLE
//  s_data_write   out  DATA_W  slave write data; 0 when IDLE
//  s_data_read    in   DATA_W  slave read data
//  s_ack          in   1       slave ack (may be combinational in same cycle as stb)
//  gnt            out  2       one-hot current grant; 00 in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, gnt=00, last=1 (master 0 wins first tie), wd_cnt=0.
//   All s_* outputs, mN_ack, mN_err and mN_data_read are 0.
//  Request: reqN = mN_cyc & mN_stb.
//  IDLE:
//   - no req: stay in IDLE.
//   - one req: grant that master.
//   - both req: grant ~last.
//   - On a grant, register gnt, set last=granted index, go BUSY next edge.
//  Latency: req at edge N -> s_stb at cycle N+1. With a combinational slave, mN_ack also
//   appears in cycle N+1. This gives 1 cycle of arbitration overhead per locked cycle.
//  BUSY:
//   - s_* mirror the granted master combinationally. Granted mN_ack = s_ack and
//     mN_data_read = s_data_read.
//   - The non-granted master sees ack=0, err=0, data_read=0. Its request is held pending.
//   - Stay BUSY while the granted mN_cyc=1; back-to-back stb pulses inside one cyc are
//     served without re-arbitration (lock).
//   - When the granted mN_cyc=0: combinationally drop s_cyc/s_stb, return to IDLE next
//     edge, and re-arbitrate from IDLE (1 dead cycle).
//  Watchdog:
//   - wd_cnt clears on s_ack, on state change and when s_stb=0. It increments each BUSY
//     cycle with s_stb=1 & s_ack=0.
//   - When wd_cnt reaches TIMEOUT-1 with no ack: pulse granted mN_err for that cycle,
//     force state to IDLE next edge, and clear wd_cnt.
//   - An ack in the same cycle as the timeout wins: ack passes, no err.
//  Master drops cyc while the slave acks: that ack is still forwarded, then go IDLE.
//  Reset mid-transfer: next edge returns to IDLE with all outputs 0. No err and no ack
//   are generated for the aborted cycle.
//  The arbiter never modifies addr, width or data; width and alignment rules belong to
//   the slave.
// TESTING
//  1 Solo: m0 reads addr 0x10, width 10, slave returns 0xDEADBEEF + ack ->
//    m0_ack=1 and m0_data_read=0xDEADBEEF in cycle 2; m1_ack=0 throughout.
//  2 Tie after reset: m0 and m1 both request at cycle 0 -> gnt=01 first. After m0 drops
//    cyc: IDLE for 1 cycle, then gnt=10. Next tie goes to m0 again.
//  3 Lock: m1 holds cyc for 3 stb pulses while m0 requests -> all 3 served to m1,
//    m0_ack=0 until m1 drops cyc, then m0 is granted.
//  4 Timeout (TIMEOUT=16): slave never acks on m0 read -> m0_err pulses exactly on the
//    16th stb cycle, s_cyc=0 the next cycle, and a pending m1 is then granted.
//  5 Reset mid-op: assert rst while gnt=10 and s_stb=1 -> next cycle gnt=00, s_cyc=0,
//    all ack/err=0. After release, a tie grants m0.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone-style port bundle shared by the arbiter's master and slave sides.
// The master modport is what a bus initiator drives; the slave modport is what a
// target drives. The err line only travels from target to initiator.
interface wb_arbiter_2m_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        width;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, addr, width, data_write,
        input  data_read, ack
    );

    modport slave (
        input  cyc, stb, we, addr, width, data_write,
        output data_read, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave Wishbone arbiter for the shared on-chip memory.
// Master 0 is instruction fetch, master 1 is the load/store unit. Grants are
// round-robin and held for the whole bus cycle (cyc lock). A watchdog ends a
// tenure with a one-cycle err pulse when the slave stalls too long.
// Bus controls and responses pass through combinationally once granted, so a
// combinational slave can ack in the first granted cycle.
module wb_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    wb_arbiter_2m_if.slave  m0,
    wb_arbiter_2m_if.slave  m1,
    wb_arbiter_2m_if.master s,
    output logic [1:0]      gnt
);
    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [1:0]      gnt_r;
    logic            last_r;
    logic [WD_W-1:0] wd_cnt_r;

    logic              req0_s;
    logic              req1_s;
    logic              busy_s;
    logic              g_cyc_s;
    logic              g_stb_s;
    logic              g_we_s;
    logic [ADDR_W-1:0] g_addr_s;
    logic [1:0]        g_width_s;
    logic [DATA_W-1:0] g_wdata_s;
    logic              s_cyc_s;
    logic              s_stb_s;
    logic              timeout_s;
    logic              sel0_s;
    logic              sel1_s;

    assign req0_s = m0.cyc & m0.stb;
    assign req1_s = m1.cyc & m1.stb;
    assign busy_s = (state_r == ST_BUSY);
    assign sel0_s = busy_s & gnt_r[0];
    assign sel1_s = busy_s & gnt_r[1];

    // Route the currently granted master's request fields toward the slave.
    always_comb begin
        g_cyc_s   = m0.cyc;
        g_stb_s   = m0.stb;
        g_we_s    = m0.we;
        g_addr_s  = m0.addr;
        g_width_s = m0.width;
        g_wdata_s = m0.data_write;
        if (gnt_r[1]) begin
            g_cyc_s   = m1.cyc;
            g_stb_s   = m1.stb;
            g_we_s    = m1.we;
            g_addr_s  = m1.addr;
            g_width_s = m1.width;
            g_wdata_s = m1.data_write;
        end else begin
            g_cyc_s   = m0.cyc;
            g_stb_s   = m0.stb;
            g_we_s    = m0.we;
            g_addr_s  = m0.addr;
            g_width_s = m0.width;
            g_wdata_s = m0.data_write;
        end
    end

    // Dropping cyc removes cyc/stb from the slave in the same cycle.
    assign s_cyc_s   = busy_s & g_cyc_s;
    assign s_stb_s   = s_cyc_s & g_stb_s;
    // A same-cycle ack beats the watchdog.
    assign timeout_s = s_stb_s & ~s.ack & (wd_cnt_r == WD_LAST);

    assign s.cyc        = s_cyc_s;
    assign s.stb        = s_stb_s;
    assign s.we         = busy_s & g_we_s;
    assign s.addr       = busy_s ? g_addr_s  : {ADDR_W{1'b0}};
    assign s.width      = busy_s ? g_width_s : 2'b00;
    assign s.data_write = busy_s ? g_wdata_s : {DATA_W{1'b0}};

    // Responses are suppressed while reset is asserted so an aborted cycle reports nothing.
    assign m0.ack       = sel0_s & s.ack & ~rst;
    assign m1.ack       = sel1_s & s.ack & ~rst;
    assign m0.err       = sel0_s & timeout_s & ~rst;
    assign m1.err       = sel1_s & timeout_s & ~rst;
    assign m0.data_read = sel0_s ? s.data_read : {DATA_W{1'b0}};
    assign m1.data_read = sel1_s ? s.data_read : {DATA_W{1'b0}};

    assign gnt = gnt_r;

    // Arbitration FSM: round-robin grant from IDLE, cyc-locked tenure, watchdog abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            gnt_r    <= 2'b00;
            last_r   <= 1'b1;
            wd_cnt_r <= WD_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wd_cnt_r <= WD_ZERO;
                    if (req0_s & req1_s) begin
                        state_r <= ST_BUSY;
                        gnt_r   <= last_r ? 2'b01 : 2'b10;
                        last_r  <= ~last_r;
                    end else if (req0_s) begin
                        state_r <= ST_BUSY;
                        gnt_r   <= 2'b01;
                        last_r  <= 1'b0;
                    end else if (req1_s) begin
                        state_r <= ST_BUSY;
                        gnt_r   <= 2'b10;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= 2'b00;
                    end
                end
                ST_BUSY: begin
                    if (timeout_s | ~g_cyc_s) begin
                        state_r  <= ST_IDLE;
                        gnt_r    <= 2'b00;
                        wd_cnt_r <= WD_ZERO;
                    end else if (s.ack | ~s_stb_s) begin
                        wd_cnt_r <= WD_ZERO;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= 2'b00;
                    wd_cnt_r <= WD_ZERO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios with literal
// expectations, then randomized traffic, all shadowed by a behavioural model
// that tracks who owns the bus and how long the slave has stalled.
module tb_wb_arbiter_2m;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;

    wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    wb_arbiter_2m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    wb_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .m0 (m0_if),
        .m1 (m1_if),
        .s  (s_if),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    // Slave behaviour: combinational ack while strobed, data chosen by the stimulus.
    logic              ack_now = 1'b0;
    logic [DATA_W-1:0] rdata   = 32'h0;
    assign s_if.err = 1'b0;
    always_comb begin
        s_if.ack       = s_if.stb & ack_now & ~s_if.err;
        s_if.data_read = rdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bus owner (-1 = nobody), last winner, consecutive stalled strobes.
    int m_owner = -1;
    int m_last  = 1;
    int m_stall = 0;
    bit armed   = 1'b0;

    // Compare every DUT output against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        int                own;
        logic              gcyc, gstb, gwe, e_scyc, e_sstb, e_ack, e_to, r0, r1;
        logic [ADDR_W-1:0] gaddr;
        logic [DATA_W-1:0] gwd;
        logic [1:0]        gw, e_gnt;
        own = m_owner;
        if (own == 1) begin
            gcyc = m1_if.cyc; gstb = m1_if.stb; gwe = m1_if.we;
            gaddr = m1_if.addr; gw = m1_if.width; gwd = m1_if.data_write;
        end else begin
            gcyc = m0_if.cyc; gstb = m0_if.stb; gwe = m0_if.we;
            gaddr = m0_if.addr; gw = m0_if.width; gwd = m0_if.data_write;
        end
        e_scyc = (own >= 0) && gcyc;
        e_sstb = e_scyc && gstb;
        e_ack  = e_sstb && ack_now;
        e_to   = e_sstb && !e_ack && (m_stall + 1 == TIMEOUT);
        e_gnt  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        if (armed) begin
            chk("gnt",     64'(gnt),             64'(e_gnt));
            chk("s_cyc",   64'(s_if.cyc),        64'(e_scyc));
            chk("s_stb",   64'(s_if.stb),        64'(e_sstb));
            chk("s_we",    64'(s_if.we),         64'((own >= 0) && gwe));
            chk("s_addr",  64'(s_if.addr),       64'((own >= 0) ? gaddr : 32'h0));
            chk("s_width", 64'(s_if.width),      64'((own >= 0) ? gw : 2'b00));
            chk("s_wdata", 64'(s_if.data_write), 64'((own >= 0) ? gwd : 32'h0));
            chk("m0_ack",  64'(m0_if.ack),       64'((own == 0) && e_ack && !rst));
            chk("m1_ack",  64'(m1_if.ack),       64'((own == 1) && e_ack && !rst));
            chk("m0_err",  64'(m0_if.err),       64'((own == 0) && e_to && !rst));
            chk("m1_err",  64'(m1_if.err),       64'((own == 1) && e_to && !rst));
            chk("m0_rd",   64'(m0_if.data_read), 64'((own == 0) ? rdata : 32'h0));
            chk("m1_rd",   64'(m1_if.data_read), 64'((own == 1) ? rdata : 32'h0));
        end
        if (rst) begin
            m_owner = -1; m_last = 1; m_stall = 0; armed = 1'b1;
        end else if (own < 0) begin
            r0 = m0_if.cyc && m0_if.stb;
            r1 = m1_if.cyc && m1_if.stb;
            if (r0 && r1)  m_owner = 1 - m_last;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
            m_stall = 0;
        end else if (e_to || !gcyc) begin
            m_owner = -1; m_stall = 0;
        end else if (e_sstb && !e_ack) begin
            m_stall++;
        end else begin
            m_stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [1:0] width, input logic [31:0] wd);
        if (n == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.addr = addr; m0_if.width = width; m0_if.data_write = wd;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.addr = addr; m1_if.width = width; m1_if.data_write = wd;
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        neg();
        chk("rst_gnt",    64'(gnt),             64'h0);
        chk("rst_s_cyc",  64'(s_if.cyc),        64'h0);
        chk("rst_s_addr", 64'(s_if.addr),       64'h0);
        chk("rst_m0_ack", 64'(m0_if.ack),       64'h0);
        chk("rst_m1_ack", 64'(m1_if.ack),       64'h0);
        chk("rst_m0_rd",  64'(m0_if.data_read), 64'h0);
        tick();
        rst = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int m1_acks;
        int ack_rate;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);

        // Solo read by m0 with an immediate slave ack.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0);
        ack_now = 1'b1; rdata = 32'hDEADBEEF;
        neg();
        chk("t1_idle_gnt", 64'(gnt), 64'h0);
        chk("t1_idle_ack", 64'(m0_if.ack), 64'h0);
        tick(); neg();
        chk("t1_gnt",  64'(gnt), 64'h1);
        chk("t1_sstb", 64'(s_if.stb), 64'h1);
        chk("t1_addr", 64'(s_if.addr), 64'h10);
        chk("t1_ack",  64'(m0_if.ack), 64'h1);
        chk("t1_rd",   64'(m0_if.data_read), 64'hDEADBEEF);
        chk("t1_m1ack", 64'(m1_if.ack), 64'h0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 2'b10, 32'h0);
        neg();
        chk("t1_drop_scyc", 64'(s_if.cyc), 64'h0);
        tick(); neg();
        chk("t1_back_idle", 64'(gnt), 64'h0);

        // Tie after reset goes to m0, then m1, then m0 again.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h100, 2'b10, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h200, 2'b01, 32'h1234);
        neg();
        chk("t2_idle", 64'(gnt), 64'h0);
        tick(); neg();
        chk("t2_gnt0", 64'(gnt), 64'h1);
        chk("t2_m1ack", 64'(m1_if.ack), 64'h0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h100, 2'b10, 32'h0);
        neg();
        chk("t2_drop_scyc", 64'(s_if.cyc), 64'h0);
        tick(); neg();
        chk("t2_dead", 64'(gnt), 64'h0);
        tick(); neg();
        chk("t2_gnt1", 64'(gnt), 64'h2);
        chk("t2_m1ack1", 64'(m1_if.ack), 64'h1);
        chk("t2_waddr", 64'(s_if.addr), 64'h200);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h200, 2'b01, 32'h0);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h100, 2'b10, 32'h0);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h200, 2'b01, 32'h1234);
        neg();
        chk("t2_idle2", 64'(gnt), 64'h0);
        tick(); neg();
        chk("t2_tie_again", 64'(gnt), 64'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        tick();

        // Lock: m1 keeps cyc over three strobes while m0 waits.
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h300, 2'b10, 32'h0);
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 2'b10, 32'h0);
        m1_acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                m1_if.stb = (i % 2 == 0);
            end
            neg();
            chk("t3_lock_gnt", 64'(gnt), 64'h2);
            chk("t3_m0_wait", 64'(m0_if.ack), 64'h0);
            if (m1_if.ack) m1_acks++;
        end
        chk("t3_m1_acks", 64'(m1_acks), 64'd3);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h300, 2'b10, 32'h0);
        neg();
        chk("t3_m0_still", 64'(m0_if.ack), 64'h0);
        tick(); neg();
        chk("t3_dead", 64'(gnt), 64'h0);
        tick(); neg();
        chk("t3_m0_gnt", 64'(gnt), 64'h1);
        chk("t3_m0_ack", 64'(m0_if.ack), 64'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        tick();

        // Watchdog: slave never acks m0; err on the 16th strobe cycle, then m1 wins.
        do_reset();
        ack_now = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 2'b10, 32'h0);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h80, 2'b10, 32'h0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k > 1) tick();
            neg();
            chk("t4_err", 64'(m0_if.err), 64'(k == TIMEOUT));
            chk("t4_gnt", 64'(gnt), 64'h1);
        end
        tick(); neg();
        chk("t4_scyc_off", 64'(s_if.cyc), 64'h0);
        chk("t4_idle", 64'(gnt), 64'h0);
        chk("t4_err_gone", 64'(m0_if.err), 64'h0);
        tick(); neg();
        chk("t4_m1_gnt", 64'(gnt), 64'h2);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        tick();

        // Reset while m1 owns the bus with stb high.
        do_reset();
        ack_now = 1'b0;
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h90, 2'b01, 32'h55);
        tick(); neg();
        chk("t5_pre_gnt", 64'(gnt), 64'h2);
        chk("t5_pre_stb", 64'(s_if.stb), 64'h1);
        tick();
        rst = 1'b1;
        ack_now = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h94, 2'b10, 32'h0);
        neg();
        chk("t5_rst_noack", 64'(m1_if.ack), 64'h0);
        tick();
        rst = 1'b0;
        neg();
        chk("t5_gnt",   64'(gnt), 64'h0);
        chk("t5_scyc",  64'(s_if.cyc), 64'h0);
        chk("t5_acks",  64'({m0_if.ack, m1_if.ack}), 64'h0);
        chk("t5_errs",  64'({m0_if.err, m1_if.err}), 64'h0);
        tick(); neg();
        chk("t5_tie_m0", 64'(gnt), 64'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        tick();

        // Randomized traffic against the model.
        ack_rate = 5;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 400 == 0) ack_rate = (c / 400) % 3 == 1 ? 0 : ((c / 400) % 3 == 2 ? 9 : 5);
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 2; n++) begin
                logic cyc_v, stb_v;
                cyc_v = (n == 0) ? m0_if.cyc : m1_if.cyc;
                stb_v = (n == 0) ? m0_if.stb : m1_if.stb;
                if (cyc_v) begin
                    if ($urandom_range(0, 19) == 0) begin
                        cyc_v = 1'b0; stb_v = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        stb_v = ~stb_v;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    cyc_v = 1'b1; stb_v = 1'b1;
                end
                set_m(n, cyc_v, stb_v, 1'($urandom_range(0, 1)), $urandom,
                      2'($urandom_range(0, 3)), $urandom);
            end
            ack_now = ($urandom_range(0, 9) < ack_rate);
            rdata   = $urandom;
        end
        tick();
        rst = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
